// File: rtl/fifo_p.sv
// fifo_p: store-and-forward packet FIFO for sop/eop-framed byte streams.
// Each packet is written into the data RAM speculatively. It is committed only
// when its eop arrives, the packet fits and the length FIFO has room. Committed
// packets are replayed as contiguous bursts.
// Optional build macro: FIFO_P_DROP_CNT_EN adds a saturating 16-bit drop counter.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   din/din_vld/din_sop/din_eop   input byte stream (no backpressure)
//   dout/dout_vld/dout_sop/dout_eop  registered output stream
//   drop_cnt                      dropped-packet count (FIFO_P_DROP_CNT_EN only)
module fifo_p #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned INFO_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    input  logic              din_sop,
    input  logic              din_eop,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic              dout_sop,
    output logic              dout_eop
`ifdef FIFO_P_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int unsigned PW     = ADDR_W + 1;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned IW     = INFO_AW + 1;
    localparam int unsigned IDEPTH = 1 << INFO_AW;

    typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP} w_state_t;
    typedef enum logic       {R_IDLE, R_SEND} r_state_t;

    logic [DATA_W-1:0] mem      [DEPTH];
    logic [PW-1:0]     info_mem [IDEPTH];

    w_state_t w_state, w_state_d;
    r_state_t r_state, r_state_d;

    logic [PW-1:0] wr_tmp, wr_tmp_d, wr_commit, wr_commit_d, len, len_d;
    logic [PW-1:0] rd_ptr, rd_ptr_d, rd_cnt, rd_cnt_d;
    logic          rd_first, rd_first_d;
    logic [IW-1:0] info_wp, info_rp;
    logic [PW-1:0] free, info_wdata;
    logic          info_full, info_empty, info_push, info_pop;
    logic          ram_we, ram_re, re_sop, re_eop;
    logic [ADDR_W-1:0] ram_wa;
    logic [DATA_W-1:0] ram_q;
    logic          s1_vld, s1_sop, s1_eop;
    logic [1:0]    drop_n;

    // Free space is measured against committed data only; speculative bytes count via len.
    assign free       = PW'(DEPTH) - (wr_commit - rd_ptr);
    assign info_empty = (info_wp == info_rp);
    assign info_full  = (info_wp[INFO_AW] != info_rp[INFO_AW]) &&
                        (info_wp[INFO_AW-1:0] == info_rp[INFO_AW-1:0]);

    // Write FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_state <= W_IDLE;
        else        w_state <= w_state_d;
    end

    // Write FSM: next state, RAM write, commit and drop decisions
    always_comb begin
        w_state_d   = w_state;
        wr_tmp_d    = wr_tmp;
        wr_commit_d = wr_commit;
        len_d       = len;
        ram_we      = 1'b0;
        ram_wa      = wr_tmp[ADDR_W-1:0];
        info_push   = 1'b0;
        info_wdata  = len + PW'(1);
        drop_n      = 2'd0;
        if (din_vld && din_sop) begin
            // A sop always restarts at the commit point, aborting any open packet.
            if (w_state == W_RECV) drop_n = 2'd1;
            wr_tmp_d = wr_commit;
            len_d    = '0;
            if (free == '0) begin
                drop_n    = drop_n + 2'd1;
                w_state_d = din_eop ? W_IDLE : W_DROP;
            end else begin
                ram_we = 1'b1;
                ram_wa = wr_commit[ADDR_W-1:0];
                if (din_eop) begin
                    w_state_d = W_IDLE;
                    if (!info_full) begin
                        info_push   = 1'b1;
                        info_wdata  = PW'(1);
                        wr_commit_d = wr_commit + PW'(1);
                        wr_tmp_d    = wr_commit + PW'(1);
                    end else begin
                        drop_n = drop_n + 2'd1;
                    end
                end else begin
                    wr_tmp_d  = wr_commit + PW'(1);
                    len_d     = PW'(1);
                    w_state_d = W_RECV;
                end
            end
        end else if (din_vld && w_state == W_RECV) begin
            if (len < free) begin
                ram_we = 1'b1;
                if (din_eop) begin
                    w_state_d = W_IDLE;
                    if (!info_full) begin
                        info_push   = 1'b1;
                        wr_commit_d = wr_tmp + PW'(1);
                        wr_tmp_d    = wr_tmp + PW'(1);
                    end else begin
                        drop_n   = 2'd1;
                        wr_tmp_d = wr_commit;
                    end
                end else begin
                    wr_tmp_d = wr_tmp + PW'(1);
                    len_d    = len + PW'(1);
                end
            end else begin
                drop_n    = 2'd1;
                wr_tmp_d  = wr_commit;
                w_state_d = din_eop ? W_IDLE : W_DROP;
            end
        end else if (din_vld && din_eop && w_state == W_DROP) begin
            w_state_d = W_IDLE;
        end
    end

    // Read FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_state_d;
    end

    // Read FSM: pop a length, then issue one RAM read per cycle for that many bytes
    always_comb begin
        r_state_d  = r_state;
        rd_ptr_d   = rd_ptr;
        rd_cnt_d   = rd_cnt;
        rd_first_d = rd_first;
        info_pop   = 1'b0;
        ram_re     = 1'b0;
        re_sop     = 1'b0;
        re_eop     = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (!info_empty) begin
                    info_pop   = 1'b1;
                    rd_cnt_d   = info_mem[info_rp[INFO_AW-1:0]];
                    rd_first_d = 1'b1;
                    r_state_d  = R_SEND;
                end
            end
            R_SEND: begin
                ram_re     = 1'b1;
                re_sop     = rd_first;
                re_eop     = (rd_cnt == PW'(1));
                rd_ptr_d   = rd_ptr + PW'(1);
                rd_cnt_d   = rd_cnt - PW'(1);
                rd_first_d = 1'b0;
                if (rd_cnt == PW'(1)) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Pointers, counters and output pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_tmp    <= '0;
            wr_commit <= '0;
            len       <= '0;
            rd_ptr    <= '0;
            rd_cnt    <= '0;
            rd_first  <= 1'b0;
            info_wp   <= '0;
            info_rp   <= '0;
            s1_vld    <= 1'b0;
            s1_sop    <= 1'b0;
            s1_eop    <= 1'b0;
            dout      <= '0;
            dout_vld  <= 1'b0;
            dout_sop  <= 1'b0;
            dout_eop  <= 1'b0;
        end else begin
            wr_tmp    <= wr_tmp_d;
            wr_commit <= wr_commit_d;
            len       <= len_d;
            rd_ptr    <= rd_ptr_d;
            rd_cnt    <= rd_cnt_d;
            rd_first  <= rd_first_d;
            if (info_push) info_wp <= info_wp + IW'(1);
            if (info_pop)  info_rp <= info_rp + IW'(1);
            s1_vld    <= ram_re;
            s1_sop    <= re_sop;
            s1_eop    <= re_eop;
            dout      <= s1_vld ? ram_q : '0;
            dout_vld  <= s1_vld;
            dout_sop  <= s1_vld & s1_sop;
            dout_eop  <= s1_vld & s1_eop;
        end
    end

    // Storage arrays carry no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (ram_we)    mem[ram_wa] <= din;
        if (ram_re)    ram_q <= mem[rd_ptr[ADDR_W-1:0]];
        if (info_push) info_mem[info_wp[INFO_AW-1:0]] <= info_wdata;
    end

`ifdef FIFO_P_DROP_CNT_EN
    // Saturating drop counter; a sop abort can coincide with a second drop.
    logic [16:0] drop_sum;
    assign drop_sum = 17'(drop_cnt) + 17'(drop_n);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt <= '0;
        else        drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
`else
    logic unused_drop;
    assign unused_drop = ^drop_n;
`endif

endmodule

// File: tb/tb_fifo_p.sv
// tb_fifo_p: directed stimulus with an expected-byte scoreboard and an
// independent output monitor for fifo_p.
module tb_fifo_p;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = '0;
    logic       din_vld = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
    logic [7:0] dout;
    logic       dout_vld, dout_sop, dout_eop;
`ifdef FIFO_P_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    fifo_p dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .din_vld  (din_vld),
        .din_sop  (din_sop),
        .din_eop  (din_eop),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_sop (dout_sop),
        .dout_eop (dout_eop)
`ifdef FIFO_P_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        logic       chk_gap;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   idle_run = 0;
    logic mon_en = 1'b0;

    // Monitor: every valid output byte is matched against the scoreboard head.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (dout_vld) begin
                n_tests++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out: got dout=%h sop=%b eop=%b, required no output",
                             dout, dout_sop, dout_eop);
                end else begin
                    mon_e = expq.pop_front();
                    if ({dout, dout_sop, dout_eop} !== {mon_e.d, mon_e.sop, mon_e.eop}) begin
                        n_fail++;
                        $display("FAIL out_byte: got dout=%h sop=%b eop=%b, required dout=%h sop=%b eop=%b",
                                 dout, dout_sop, dout_eop, mon_e.d, mon_e.sop, mon_e.eop);
                    end
                    if (mon_e.chk_gap) begin
                        n_tests++;
                        if (idle_run != 1) begin
                            n_fail++;
                            $display("FAIL pkt_gap: got %0d idle cycles, required 1", idle_run);
                        end
                    end
                end
                idle_run = 0;
            end else begin
                idle_run++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Drives one beat; entered and left just after a rising edge.
    task automatic beat(input logic [7:0] d, input logic s, input logic e);
        din = d; din_vld = 1'b1; din_sop = s; din_eop = e;
        @(posedge clk); #1;
        din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic [7:0] first, input bit sop_first,
                            input bit eop_last, input bit expect_out, input bit gap_first);
        exp_t e;
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = first + 8'(i);
            if (expect_out) begin
                e.d = d; e.sop = (i == 0); e.eop = (i == n - 1); e.chk_gap = gap_first && (i == 0);
                expq.push_back(e);
            end
            beat(d, sop_first && (i == 0), eop_last && (i == n - 1));
        end
    endtask

    // Called right after the eop edge E: dout_vld must rise at edge E+3.
    task automatic check_latency(input string name);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 3) check({name, "_early"}, 32'(dout_vld), 32'd0);
            if (k == 4) check(name, 32'({dout_vld, dout_sop}), 32'b11);
        end
    endtask

    task automatic wait_drain(input string name, input int max);
        int c = 0;
        while (expq.size() != 0 && c < max) begin
            @(negedge clk);
            c++;
        end
        check(name, 32'(expq.size()), 32'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", 32'({dout, dout_vld, dout_sop, dout_eop}), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_outputs", 32'({dout, dout_vld, dout_sop, dout_eop}), 32'd0);
`ifdef FIFO_P_DROP_CNT_EN
        check("drop_cnt_rst", 32'(drop_cnt), 32'd0);
`endif

        // 1532-byte packet with latency check
        send_pkt(1532, 8'd1, 1, 1, 1, 0);
        check_latency("lat_1532");
        wait_drain("drain_1532", 3000);

        // 20 idle cycles, 1559-byte packet, then a single byte right behind it
        repeat (20) @(posedge clk);
        #1;
        send_pkt(1559, 8'd1, 1, 1, 1, 0);
        send_pkt(1, 8'hA5, 1, 1, 1, 1);
        wait_drain("drain_1559", 3000);

        // Single-beat packet
        send_pkt(1, 8'h5A, 1, 1, 1, 0);
        check_latency("lat_single");
        check("single_byte", 32'({dout, dout_sop, dout_eop}), 32'({8'h5A, 2'b11}));
        wait_drain("drain_single", 50);

        // Oversize drop, then a short packet
        send_pkt(2049, 8'd0, 1, 1, 0, 0);
        send_pkt(10, 8'h30, 1, 1, 1, 0);
        wait_drain("drain_after_2049", 100);
`ifdef FIFO_P_DROP_CNT_EN
        check("drop_cnt_ovf", 32'(drop_cnt), 32'd1);
`endif

        // Exactly the maximum packet length is accepted
        send_pkt(2048, 8'h77, 1, 1, 1, 0);
        wait_drain("drain_2048", 3000);

        // sop abort: only the second packet survives
        send_pkt(100, 8'h00, 1, 0, 0, 0);
        send_pkt(5, 8'hC0, 1, 1, 1, 0);
        wait_drain("drain_abort", 100);
`ifdef FIFO_P_DROP_CNT_EN
        check("drop_cnt_abort", 32'(drop_cnt), 32'd2);
`endif

        // Length FIFO full: 16 singles queue behind a long packet, the 17th drops
        send_pkt(1000, 8'h01, 1, 1, 1, 0);
        for (int i = 0; i < 17; i++) send_pkt(1, 8'(8'h80 + 8'(i)), 1, 1, i < 16, 0);
        wait_drain("drain_info_full", 3000);
`ifdef FIFO_P_DROP_CNT_EN
        check("drop_cnt_info_full", 32'(drop_cnt), 32'd3);
`endif

        // Reset mid-output and mid-input
        send_pkt(200, 8'h10, 1, 1, 1, 0);
        send_pkt(100, 8'h40, 1, 0, 0, 0);
        rst_n = 1'b0;
        expq.delete();
        #1;
        check("midrst_outputs", 32'({dout, dout_vld, dout_sop, dout_eop}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
`ifdef FIFO_P_DROP_CNT_EN
        check("drop_cnt_midrst", 32'(drop_cnt), 32'd0);
`endif
        send_pkt(200, 8'hA4, 0, 1, 0, 0);
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_quiet", 32'(dout_vld), 32'd0);
        send_pkt(7, 8'hE0, 1, 1, 1, 0);
        wait_drain("drain_post_rst", 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
